// File: rtl/hamming_scrub_ctrl.sv
// rtl/hamming_scrub_ctrl.sv - background scrubber for a memory of Hamming (7,4) codewords
// Optional HAMMING_SCRUB_LOG_EN adds err_addr/err_syndrome capture of the last corrected word.
module hamming_scrub_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int INTERVAL = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr_count,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [6:0]        mem_wdata,
  input  logic [6:0]        mem_rdata,
  input  logic              mem_ack,
`ifdef HAMMING_SCRUB_LOG_EN
  output logic [ADDR_W-1:0] err_addr,
  output logic [2:0]        err_syndrome,
`endif
  output logic [7:0]        err_count
);

  localparam int GAP_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CHECK, S_WRITE, S_NEXT, S_GAP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [6:0]         r_wdata;
  logic [6:0]         r_cap;
  logic [7:0]         r_count;
  logic [GAP_W-1:0]   r_gap;
  logic               r_done;
  logic [2:0]         w_syn;
  logic [6:0]         w_fix;
  logic               w_last;

  // Syndrome value is the 1-based position of the flipped bit.
  assign w_syn  = {r_cap[3] ^ r_cap[4] ^ r_cap[5] ^ r_cap[6],
                   r_cap[1] ^ r_cap[2] ^ r_cap[5] ^ r_cap[6],
                   r_cap[0] ^ r_cap[2] ^ r_cap[4] ^ r_cap[6]};
  assign w_fix  = r_cap ^ (7'd1 << (w_syn - 3'd1));
  assign w_last = (r_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ:  if (mem_ack) w_next = S_CHECK;
      S_CHECK: w_next = (w_syn != 3'd0) ? S_WRITE : S_NEXT;
      S_WRITE: if (mem_ack) w_next = S_NEXT;
      S_NEXT: begin
        if (w_last)             w_next = S_IDLE;
        else if (INTERVAL == 0) w_next = S_READ;
        else                    w_next = S_GAP;
      end
      S_GAP:   if (r_gap == '0) w_next = S_READ;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    mem_req = (r_state == S_READ) || (r_state == S_WRITE);
    mem_we  = (r_state == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_cap   <= '0;
      r_gap   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_NEXT) && w_last;
      case (r_state)
        S_IDLE:  if (start) r_addr <= '0;
        S_READ:  if (mem_ack) r_cap <= mem_rdata;
        S_CHECK: if (w_syn != 3'd0) r_wdata <= w_fix;
        S_NEXT: begin
          if (!w_last) begin
            r_addr <= r_addr + 1'b1;
            r_gap  <= GAP_W'((INTERVAL > 0) ? INTERVAL - 1 : 0);
          end
        end
        S_GAP:   if (r_gap != '0) r_gap <= r_gap - 1'b1;
        default: ;
      endcase
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr_count) begin
      r_count <= '0;
    end else if ((r_state == S_CHECK) && (w_syn != 3'd0) && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

`ifdef HAMMING_SCRUB_LOG_EN
  logic [ADDR_W-1:0] r_err_addr;
  logic [2:0]        r_err_syn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_addr <= '0;
      r_err_syn  <= '0;
    end else if ((r_state == S_CHECK) && (w_syn != 3'd0)) begin
      r_err_addr <= r_addr;
      r_err_syn  <= w_syn;
    end
  end

  assign err_addr     = r_err_addr;
  assign err_syndrome = r_err_syn;
`endif

  assign done      = r_done;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign err_count = r_count;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// tb/tb_hamming_scrub_ctrl.sv - scoreboard bench for hamming_scrub_ctrl
// A second instance with INTERVAL=8 covers the gap timing and start-while-busy.
module tb_hamming_scrub_ctrl;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clr_count = 1'b0;
  logic          busy, done, mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [6:0]    mem_wdata, mem_rdata;
  logic [7:0]    err_count;

  logic          g_start = 1'b0;
  logic          g_busy, g_done, g_req, g_we;
  logic [AW-1:0] g_addr;
  logic [6:0]    g_wdata;
  logic [7:0]    g_count;
`ifdef HAMMING_SCRUB_LOG_EN
  logic [AW-1:0] err_addr, g_err_addr;
  logic [2:0]    err_syndrome, g_err_syndrome;
`endif

  hamming_scrub_ctrl #(.ADDR_W(AW), .DEPTH(4), .INTERVAL(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr_count(clr_count),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef HAMMING_SCRUB_LOG_EN
    .err_addr(err_addr), .err_syndrome(err_syndrome),
`endif
    .err_count(err_count)
  );

  hamming_scrub_ctrl #(.ADDR_W(AW), .DEPTH(4), .INTERVAL(8)) u_gap (
    .clk(clk), .rst_n(rst_n), .start(g_start), .clr_count(1'b0),
    .busy(g_busy), .done(g_done), .mem_req(g_req), .mem_we(g_we),
    .mem_addr(g_addr), .mem_wdata(g_wdata), .mem_rdata(7'h55), .mem_ack(g_req),
`ifdef HAMMING_SCRUB_LOG_EN
    .err_addr(g_err_addr), .err_syndrome(g_err_syndrome),
`endif
    .err_count(g_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: contents loaded by the stimulus only; writes are checked, not stored.
  logic [6:0] mem [16];
  int         wait_cyc = 0;
  int         ack_cnt = 0;
  assign mem_ack   = mem_req && (ack_cnt >= wait_cyc);
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) ack_cnt <= (mem_req && !mem_ack) ? ack_cnt + 1 : 0;

  logic [11:0] exp_q[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          t_first = -1;
  int          t_done = 0;
  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  logic [11:0] p_acc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [11:0] acc;
    logic [11:0] exp_acc;
    acc = {mem_we, mem_addr, mem_we ? mem_wdata : 7'd0};
    if (rst_n) begin
      if (p_req && !p_ack && mem_req) check_eq("hold", acc, p_acc);
      if (p_req && p_ack) check_eq("req_drop", mem_req, 0);
      if (mem_req && !mem_we && t_first < 0) t_first = cyc;
      if (mem_req && mem_ack) begin
        exp_acc = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
        check_eq("access", acc, exp_acc);
      end
      if (done) begin
        done_cnt++;
        t_done = cyc;
      end
    end
    p_req = mem_req;
    p_ack = mem_ack;
    p_acc = acc;
  end

  int g_last_rd = -1;
  int g_first = -1;
  int g_done_cnt = 0;
  int g_t_done = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (g_req) begin
        if (g_first < 0) g_first = cyc;
        if (g_last_rd >= 0) check_eq("gap_spacing", cyc - g_last_rd, 11);
        g_last_rd = cyc;
      end
      if (g_done) begin
        g_done_cnt++;
        g_t_done = cyc;
      end
    end
  end

  int inj[4];
  int exp_cnt = 0;

  task automatic load_expect();
    for (int i = 0; i < 4; i++) begin
      mem[i] = (inj[i] >= 0) ? (7'h55 ^ 7'(1 << inj[i])) : 7'h55;
      exp_q.push_back({1'b0, 4'(i), 7'd0});
      if (inj[i] >= 0) begin
        exp_q.push_back({1'b1, 4'(i), 7'h55});
        if (exp_cnt < 255) exp_cnt++;
      end
    end
  endtask

  task automatic pulse_start();
    t_first = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_pass(input string tag);
    int d0;
    load_expect();
    d0 = done_cnt;
    pulse_start();
    for (int k = 0; k < 2000 && done_cnt == d0; k++) @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_done"}, done_cnt - d0, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_count"}, err_count, exp_cnt);
    check_eq({tag, "_sb"}, exp_q.size(), 0);
  endtask

  // Pulse clr_count during the CHECK of address 0 (errored word).
  task automatic clr_pass(input string tag);
    fork
      run_pass(tag);
      begin
        for (int k = 0; k < 200 && !(mem_req && mem_ack && !mem_we); k++) @(negedge clk);
        @(negedge clk); clr_count = 1'b1; exp_cnt = 0;
        @(negedge clk); clr_count = 1'b0;
      end
    join
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 7'h55;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_count", err_count, 0);
`ifdef HAMMING_SCRUB_LOG_EN
    check_eq("rst_log_addr", err_addr, 0);
    check_eq("rst_log_syn", err_syndrome, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    inj = '{-1, -1, -1, -1};
    run_pass("clean");
    check_eq("clean_latency", t_done - t_first, 12);

    inj = '{-1, -1, 4, -1};
    run_pass("single");
`ifdef HAMMING_SCRUB_LOG_EN
    check_eq("log_addr", err_addr, 2);
    check_eq("log_syn", err_syndrome, 5);
`endif

    wait_cyc = 3;
    inj = '{-1, 0, -1, 6};
    run_pass("wait");
`ifdef HAMMING_SCRUB_LOG_EN
    check_eq("log_addr_w", err_addr, 3);
    check_eq("log_syn_w", err_syndrome, 7);
`endif
    wait_cyc = 0;

    @(negedge clk); g_start = 1'b1;
    @(negedge clk); g_start = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("g_busy_mid", g_busy, 1);
    g_start = 1'b1;
    @(negedge clk); g_start = 1'b0;
    for (int k = 0; k < 300 && g_done_cnt == 0; k++) @(negedge clk);
    repeat (40) @(negedge clk);
    check_eq("g_done_cnt", g_done_cnt, 1);
    check_eq("g_latency", g_t_done - g_first, 36);
    check_eq("g_busy_end", g_busy, 0);

    inj = '{1, 3, 5, 2};
    for (int p = 0; p < 80 && exp_cnt < 255; p++) run_pass("fill");
    check_eq("sat_reach", err_count, 255);
    run_pass("sat_hold");
    inj = '{0, -1, -1, -1};
    clr_pass("clr_sat");
    clr_pass("clr_race");

    wait_cyc = 3;
    exp_cnt = 0;
    inj = '{-1, 2, -1, -1};
    load_expect();
    pulse_start();
    for (int k = 0; k < 200 && !(mem_req && mem_we); k++) @(negedge clk);
    check_eq("rst_in_write", mem_req && mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_req", mem_req, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_count", err_count, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    exp_cnt = 0;
    run_pass("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_scrub_ctrl.md
# hamming_scrub_ctrl

Background scrubber for a memory of Hamming (7,4) codewords. On each `start` pulse it makes one pass over addresses 0..DEPTH-1. For each address it reads the codeword, computes the 3-bit syndrome, and writes back the single-bit-corrected codeword when the syndrome is nonzero. It sits beside the single-error decoder on the storage side, owns the memory port during a pass, and keeps a saturating count of corrected words.

## Interface
Parameters:
- `ADDR_W`, 4, memory address width.
- `DEPTH`, 16, words scrubbed per pass; legal range 1..2^ADDR_W.
- `INTERVAL`, 8, idle gap cycles between words; 0 means back-to-back.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `clr_count`  in  1  synchronous clear of `err_count`.
- `busy`  out  1  high while a pass is in progress.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  ADDR_W  access address.
- `mem_wdata`  out  7  corrected codeword for writes.
- `mem_rdata`  in  7  read codeword; valid when `mem_ack` is high during a read.
- `mem_ack`  in  1  access complete.
- `err_count`  out  8  corrected words, saturating at 255.

## Operation
- States: IDLE, READ, CHECK, WRITE, NEXT, GAP.
- IDLE:
  - On `start`=1: `mem_addr` := 0, go to READ.
  - On `start`=0: stay in IDLE.
- READ:
  - Drive `mem_req`=1, `mem_we`=0.
  - When `mem_ack`=1: latch `mem_rdata` into the capture register c, go to CHECK.
- CHECK (exactly one cycle):
  - Syndrome bits:
    - s0 = c0^c2^c4^c6
    - s1 = c1^c2^c5^c6
    - s2 = c3^c4^c5^c6
  - s != 0:
    - `mem_wdata` := c with bit (s-1) inverted.
    - Increment `err_count` (saturating).
    - Go to WRITE.
  - s == 0: go to NEXT; the memory is not written.
- WRITE:
  - Drive `mem_req`=1, `mem_we`=1, `mem_wdata` held.
  - When `mem_ack`=1: go to NEXT.
- NEXT:
  - If `mem_addr` == DEPTH-1: pulse `done`, go to IDLE.
  - Otherwise: `mem_addr`+1.
    - INTERVAL == 0: go to READ.
    - INTERVAL > 0: load the gap counter with INTERVAL-1, go to GAP.
- GAP: decrement the counter; go to READ after it reaches 0 (INTERVAL cycles spent in GAP).
- Handshake rules:
  - `mem_req` stays high until the cycle in which `mem_ack` is sampled high, and is low in the following cycle.
  - `mem_ack` is ignored while `mem_req` is low.
  - Zero-wait memories may assert `mem_ack` in the same cycle as `mem_req`.
- Address and data hold: `mem_addr` and `mem_wdata` are stable for the whole request.
- Ignored inputs: `start` while `busy`=1 is ignored.
- Counter rules:
  - `clr_count` and an increment in the same cycle: the clear wins, result 0.
  - `err_count` at 255 stays at 255.
- Multi-bit errors: double errors alias to a single-bit syndrome and are "corrected" as such; this is inherent to (7,4), not flagged.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - State IDLE.
  - `busy`, `done`, `mem_req`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `err_count`, gap counter = 0.
- Reset mid-pass: `mem_req` drops immediately and the pass is abandoned; no partial write completion is required.
- `busy`: high from the cycle after `start` is sampled until the cycle after the final NEXT, when `done`=1, `busy`=0 and the state is IDLE.
- Per-word cost, zero-wait memory, INTERVAL=0:
  - Clean word: 3 cycles (READ, CHECK, NEXT).
  - Corrected word: 4 cycles.
- Full clean pass, zero-wait memory: DEPTH*(3+INTERVAL) - INTERVAL cycles from the first READ to `done`.

## Configuration
- `HAMMING_SCRUB_LOG_EN` defined:
  - Adds outputs `err_addr` (ADDR_W) and `err_syndrome` (3).
  - Both are loaded in CHECK whenever s != 0 and hold the last corrected location.
  - Reset to 0; not cleared by `clr_count`.
- `HAMMING_SCRUB_LOG_EN` undefined: the ports and their registers are absent; all other behaviour is identical.

## Test plan
- Clean memory: DEPTH=4, INTERVAL=0, all words 0x55, zero-wait ack, `start` pulse.
  - 4 reads, no writes.
  - `done` 12 cycles after the first READ.
  - `err_count`=0.
- Single error: address 2 holds 0x45 (0x55 with bit 4 flipped).
  - s=5.
  - One write to address 2 with `mem_wdata`=0x55.
  - `err_count`=1; with LOG_EN, `err_addr`=2 and `err_syndrome`=5.
- Wait states: `mem_ack` delayed 3 cycles on every access.
  - `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` held stable until ack.
  - `mem_req` low in the cycle after ack.
- Gap and start-while-busy: INTERVAL=8, `start` pulsed again mid-pass.
  - Exactly 8 idle cycles between consecutive READs.
  - The second `start` is ignored; a single `done`.
- Counter saturation and clear: preload 255 errors, then pulse `clr_count` in the same cycle as a CHECK increment.
  - Count holds at 255.
  - Then reads 0 after the clear.
- Async reset: assert `rst_n`=0 during WRITE.
  - `mem_req`=0 immediately, `busy`=0.
  - After release, the next `start` restarts at address 0.
